ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port, asynchronous-read `ram` block. It shares the RAM between the core's instruction-fetch port (read-only) and load/store data port (read/write) using round-robin arbitration. It converts byte addresses to RAM word addresses and rejects misaligned or out-of-range accesses. It registers read data, so each requester sees a fixed two-cycle response latency.

---
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store ports in front of a
// single-port asynchronous-read RAM; fixed two-cycle response latency per request.
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_gnt,
    output logic                      if_rvalid,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_err,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_err,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic                      ram_we,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);

    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t                    state_q, state_d;
    logic                      last_gnt_q, last_gnt_d;
    logic                      owner_q, owner_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      err_q, err_d;

    logic                      if_rvalid_q, if_rvalid_d;
    logic                      if_err_q, if_err_d;
    logic [DATA_WIDTH-1:0]     if_rdata_q, if_rdata_d;
    logic                      d_rvalid_q, d_rvalid_d;
    logic                      d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0]     d_rdata_q, d_rdata_d;

    // Word-aligned and inside the RAM; there is no wrap-around.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2] != '0);
    endfunction

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    d_gnt  = d_req & (~if_req | (last_gnt_q == OWN_F));
                    if_gnt = if_req & ~d_gnt;
                end
                if (d_gnt) begin
                    owner_d    = OWN_D;
                    addr_d     = d_addr[RAM_ADDR_WIDTH+1:2];
                    we_d       = d_we;
                    wdata_d    = d_wdata;
                    err_d      = addr_err(d_addr);
                    last_gnt_d = OWN_D;
                    state_d    = ACCESS;
                end else if (if_gnt) begin
                    owner_d    = OWN_F;
                    addr_d     = if_addr[RAM_ADDR_WIDTH+1:2];
                    we_d       = 1'b0;
                    err_d      = addr_err(if_addr);
                    last_gnt_d = OWN_F;
                    state_d    = ACCESS;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Responses are built at the edge closing ACCESS; only the owner's registers move.
    always_comb begin
        if_rvalid_d = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        if (state_q == ACCESS) begin
            if (owner_q == OWN_F) begin
                if_rvalid_d = 1'b1;
                if_err_d    = err_q;
                if_rdata_d  = err_q ? '0 : ram_rdata;
            end else begin
                d_rvalid_d = 1'b1;
                d_err_d    = err_q;
                if (!we_q) d_rdata_d = err_q ? '0 : ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= OWN_F;
            owner_q     <= OWN_F;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign ram_we      = (state_q == ACCESS) & we_q & ~err_q;
    assign ram_address = addr_q;
    assign ram_wdata   = wdata_q;
    assign if_rvalid   = if_rvalid_q;
    assign if_err      = if_err_q;
    assign if_rdata    = if_rdata_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_err       = d_err_q;
    assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, corner sequences, and randomized traffic
// checked every cycle against a transaction-level model with its own memory image.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [16:0] ram_address;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;

    int vectors = 0;
    int miscompares = 0;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_address(ram_address), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int w);
        return 32'h5A5A0000 ^ w;
    endfunction

    // RAM: asynchronous read, write at the rising edge.
    logic [31:0] mem [0:131071];
    bit mem_ready = 1'b0;
    assign ram_rdata = mem[ram_address];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 131072; i++) mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_address] <= ram_wdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          port;   // 1 = data
        int          due;
        bit          err;
        bit          we;
        int          word;
        logic [31:0] wdata;
    } rsp_t;

    rsp_t        mq[$];
    logic [31:0] ref_w [int];
    int          cyc = 0;
    bit          last_d = 1'b0;
    logic [31:0] e_if_rd = '0, e_d_rd = '0;

    function automatic logic [31:0] mem_rd(input int w);
        return ref_w.exists(w) ? ref_w[w] : pat(w);
    endfunction

    function automatic bit a_err(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 32'h80000);
    endfunction

    function automatic int a_word(input logic [31:0] a);
        return int'((a / 4) % 32'h20000);
    endfunction

    always @(negedge clk) begin
        bit   e_we, e_ifv, e_dv, e_iferr, e_derr, e_fg, e_dg;
        rsp_t r;
        if (rst) begin
            mq.delete();
            last_d  = 1'b0;
            e_if_rd = '0;
            e_d_rd  = '0;
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_if_err", if_err, 0);
            chk("rst_d_err", d_err, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_ram_address", ram_address, 0);
            chk("rst_ram_wdata", ram_wdata, 0);
        end else begin
            e_we = 0; e_ifv = 0; e_dv = 0; e_iferr = 0; e_derr = 0;
            if (mq.size() != 0 && mq[0].due == cyc + 1) begin
                e_we = mq[0].we && !mq[0].err;
                chk("m_ram_address", ram_address, mq[0].word);
                if (e_we) chk("m_ram_wdata", ram_wdata, mq[0].wdata);
            end else if (mq.size() != 0 && mq[0].due == cyc) begin
                r = mq.pop_front();
                if (r.port) begin
                    e_dv = 1; e_derr = r.err;
                    if (!r.we) e_d_rd = r.err ? 32'h0 : mem_rd(r.word);
                    else if (!r.err) ref_w[r.word] = r.wdata;
                end else begin
                    e_ifv = 1; e_iferr = r.err;
                    e_if_rd = r.err ? 32'h0 : mem_rd(r.word);
                end
            end
            e_fg = (mq.size() == 0) && if_req && (!d_req || last_d);
            e_dg = (mq.size() == 0) && d_req && (!if_req || !last_d);
            chk("m_if_gnt", if_gnt, e_fg);
            chk("m_d_gnt", d_gnt, e_dg);
            chk("m_ram_we", ram_we, e_we);
            chk("m_if_rvalid", if_rvalid, e_ifv);
            chk("m_d_rvalid", d_rvalid, e_dv);
            if (e_ifv) chk("m_if_err", if_err, e_iferr);
            if (e_dv) chk("m_d_err", d_err, e_derr);
            chk("m_if_rdata", if_rdata, e_if_rd);
            chk("m_d_rdata", d_rdata, e_d_rd);
            if (e_fg) begin
                mq.push_back('{1'b0, cyc + 2, a_err(if_addr), 1'b0, a_word(if_addr), 32'h0});
                last_d = 1'b0;
            end
            if (e_dg) begin
                mq.push_back('{1'b1, cyc + 2, a_err(d_addr), d_we, a_word(d_addr), d_wdata});
                last_d = 1'b1;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [16:0] word;
        logic [31:0] rdata;   // d_rdata expected after the response
    } vec_t;

    vec_t tbl [10];

    // Called at posedge+1 with the arbiter idle; returns at posedge+1 three cycles later.
    task automatic do_d(input vec_t v);
        d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        @(negedge clk);
        chk("tbl_gnt", d_gnt, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("tbl_ram_we", ram_we, v.we && !v.err);
        chk("tbl_ram_address", ram_address, v.word);
        chk("tbl_early_rvalid", d_rvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("tbl_rvalid", d_rvalid, 1);
        chk("tbl_err", d_err, v.err);
        chk("tbl_rdata", d_rdata, v.rdata);
        @(posedge clk); #1;
    endtask

    task automatic do_f(input logic [31:0] a, input logic [31:0] exp_rd);
        if_req = 1'b1; if_addr = a;
        @(negedge clk);
        chk("f_gnt", if_gnt, 1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("f_ram_we", ram_we, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("f_rvalid", if_rvalid, 1);
        chk("f_err", if_err, 0);
        chk("f_rdata", if_rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r = $urandom_range(0, 9);
        logic [31:0] w = 32'($urandom_range(0, 31)) << 2;
        if (r <= 5) return w;
        if (r == 6) return w | 32'($urandom_range(1, 3));
        if (r == 7) return 32'h7FFFC;
        if (r == 8) return 32'h80000 | (32'($urandom_range(0, 15)) << 2);
        return $urandom();
    endfunction

    initial begin
        bit hf, hd;
        tbl[0] = '{1'b1, 32'h0000_0100, 32'hDEADBEEF, 1'b0, 17'h00040, 32'h0};
        tbl[1] = '{1'b0, 32'h0000_0100, 32'h0,        1'b0, 17'h00040, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h0000_0102, 32'h12345678, 1'b1, 17'h00040, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 32'h0000_0100, 32'h0,        1'b0, 17'h00040, 32'hDEADBEEF};
        tbl[4] = '{1'b0, 32'h0008_0000, 32'h0,        1'b1, 17'h00000, 32'h0};
        tbl[5] = '{1'b1, 32'h0007_FFFC, 32'hCAFEF00D, 1'b0, 17'h1FFFF, 32'h0};
        tbl[6] = '{1'b0, 32'h0007_FFFC, 32'h0,        1'b0, 17'h1FFFF, 32'hCAFEF00D};
        tbl[7] = '{1'b0, 32'h0007_FFFD, 32'h0,        1'b1, 17'h1FFFF, 32'h0};
        tbl[8] = '{1'b1, 32'hFFFF_0100, 32'h00000077, 1'b1, 17'h1C040, 32'h0};
        tbl[9] = '{1'b0, 32'h0000_0100, 32'h0,        1'b0, 17'h00040, 32'hDEADBEEF};

        idle(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) do_d(tbl[i]);

        // Fetch and data responses stay in their own registers.
        do_d('{1'b1, 32'h300, 32'h11, 1'b0, 17'h000C0, 32'hDEADBEEF});
        do_f(32'h300, 32'h11);
        chk("iso_d_rdata_after_fetch", d_rdata, 32'hDEADBEEF);
        do_d('{1'b1, 32'h304, 32'h99, 1'b0, 17'h000C1, 32'hDEADBEEF});
        chk("iso_if_rdata_after_store", if_rdata, 32'h11);

        // Fetch-only streaming: grant every other cycle, rvalid with the next grant.
        if_req = 1'b1; if_addr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("str_if_gnt", if_gnt, (c % 2) == 0);
            chk("str_if_rvalid", if_rvalid, (c >= 2) && (c % 2 == 0));
            chk("str_ram_we", ram_we, 0);
            if (c == 2) chk("str_rdata0", if_rdata, pat(0));
            if (c == 4) chk("str_rdata1", if_rdata, pat(1));
            @(posedge clk); #1;
            if (c % 2 == 0) if_addr = if_addr + 32'd4;
        end
        if_req = 1'b0;
        idle(3);

        // Contention held across reset: D, F, D, F at cycles 0, 2, 4, 6.
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        idle(2);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_d_gnt", d_gnt, (c % 4) == 0);
            chk("rr_if_gnt", if_gnt, (c % 4) == 2);
            chk("rr_d_rvalid", d_rvalid, (c % 4) == 2);
            chk("rr_if_rvalid", if_rvalid, (c >= 4) && (c % 4 == 0));
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(3);

        // Reset during a store's ACCESS cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        @(negedge clk);
        chk("mid_gnt", d_gnt, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("mid_we_before", ram_we, 1);
        #1 rst = 1'b1;
        #1 chk("mid_we_after", ram_we, 0);
        @(negedge clk);
        chk("mid_no_rvalid", d_rvalid, 0);
        idle(2);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_d_gnt", d_gnt, c == 0);
            chk("post_if_gnt", if_gnt, c == 2);
            chk("post_d_rvalid", d_rvalid, c == 2);
            if (c == 2) chk("post_ram_unchanged", d_rdata, pat(32'h80));
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(3);

        // Randomized traffic; requesters hold until granted.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hf = if_req && if_gnt;
            hd = d_req && d_gnt;
            @(posedge clk); #1;
            if (!if_req || hf) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = rnd_addr();
            end
            if (!d_req || hd) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = rnd_addr();
                d_wdata = $urandom();
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
